// File: rtl/register_bank_pkg.sv
// Shared definitions for the register bank slice.
//   ZERO_REG          : address of the hard-wired zero register
//   DEFAULT_*         : default widths/depth used by the bank, its interface
//                       and the dump controller
//   dump_state_t      : states of the debug dump stream (IDLE, SEND, DONE)
package register_bank_pkg;

  localparam int ZERO_REG           = 0;
  localparam int DEFAULT_BUS_WIDTH  = 32;
  localparam int DEFAULT_REG_COUNT  = 32;
  localparam int DEFAULT_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } dump_state_t;

endpackage

// File: rtl/register_bank_if.sv
// Bus interface of the register bank.
//   Write-back : i_write_enable, i_addr_wr, i_data_wr
//   Decode read: i_addr_a, i_addr_b -> o_data_a, o_data_b (combinational)
//   Debug dump : i_dump_start, i_dump_ready -> o_dump_valid, o_dump_addr,
//                o_dump_data, o_dump_busy, o_dump_done
// Modports: master drives the requests (pipeline / debugger side),
//           slave is the register bank itself.
interface register_bank_if
  import register_bank_pkg::*;
#(
  parameter int BUS_WIDTH  = DEFAULT_BUS_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);

  logic                  i_write_enable;
  logic [ADDR_WIDTH-1:0] i_addr_wr;
  logic [BUS_WIDTH-1:0]  i_data_wr;
  logic [ADDR_WIDTH-1:0] i_addr_a;
  logic [ADDR_WIDTH-1:0] i_addr_b;
  logic [BUS_WIDTH-1:0]  o_data_a;
  logic [BUS_WIDTH-1:0]  o_data_b;
  logic                  i_dump_start;
  logic                  i_dump_ready;
  logic                  o_dump_valid;
  logic [ADDR_WIDTH-1:0] o_dump_addr;
  logic [BUS_WIDTH-1:0]  o_dump_data;
  logic                  o_dump_busy;
  logic                  o_dump_done;

  modport master (
    output i_write_enable, i_addr_wr, i_data_wr, i_addr_a, i_addr_b,
           i_dump_start, i_dump_ready,
    input  o_data_a, o_data_b, o_dump_valid, o_dump_addr, o_dump_data,
           o_dump_busy, o_dump_done
  );

  modport slave (
    input  i_write_enable, i_addr_wr, i_data_wr, i_addr_a, i_addr_b,
           i_dump_start, i_dump_ready,
    output o_data_a, o_data_b, o_dump_valid, o_dump_addr, o_dump_data,
           o_dump_busy, o_dump_done
  );

endinterface

// File: rtl/register_bank_dump_ctrl.sv
// Sequencer for the debug dump stream: walks an index from 0 to
// REG_COUNT-1, advancing on each accepted beat, then raises a one-cycle
// done pulse. The data itself is looked up by the parent bank.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start           : dump request (ignored while busy)
//   ready           : consumer accepts the current beat
//   valid, index    : current beat and the register it refers to
//   busy, done      : stream in progress / completion pulse
module register_bank_dump_ctrl
  import register_bank_pkg::*;
#(
  parameter int REG_COUNT  = DEFAULT_REG_COUNT,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  ready,
  output logic                  valid,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] index
);

  localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = ADDR_WIDTH'(REG_COUNT - 1);

  dump_state_t state;

  // All outputs are registered and move together with the state, so valid
  // and index hold steady through any number of stalled cycles. The index
  // stops at LAST_INDEX and leaves through DONE rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      index <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= SEND;
            index <= '0;
            valid <= 1'b1;
            busy  <= 1'b1;
          end
        end
        SEND: begin
          if (valid && ready) begin
            if (index == LAST_INDEX) begin
              state <= DONE;
              valid <= 1'b0;
              done  <= 1'b1;
            end else begin
              index <= index + ADDR_WIDTH'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/register_bank.sv
// General-purpose register file with two combinational read ports, one
// write-back port and a debug dump stream of the whole array.
// Ports:
//   i_clk, i_reset : clock, asynchronous active-high reset
//   bus            : register_bank_if slave (write-back, reads, dump stream)
// Build option: define REGISTER_BANK_BYPASS_EN to forward same-cycle
// write-back data to every read (ports a/b and dump). Without it, reads
// always return stored contents.
module register_bank
  import register_bank_pkg::*;
#(
  parameter int BUS_WIDTH  = DEFAULT_BUS_WIDTH,
  parameter int REG_COUNT  = DEFAULT_REG_COUNT,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic           i_clk,
  input  logic           i_reset,
  register_bank_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

  // The address decode assumes every address maps to exactly one register.
  if (REG_COUNT != (1 << ADDR_WIDTH)) begin : g_size_check
    $error("register_bank: REG_COUNT must equal 2**ADDR_WIDTH");
  end

  logic [BUS_WIDTH-1:0]  regs [REG_COUNT];
  logic                  write_hit;
  logic [ADDR_WIDTH-1:0] dump_index;
  logic [BUS_WIDTH-1:0]  stored_a;
  logic [BUS_WIDTH-1:0]  stored_b;
  logic [BUS_WIDTH-1:0]  stored_dump;

  assign write_hit = bus.i_write_enable && (bus.i_addr_wr != ZERO_ADDR);

  // Storage: register 0 is never written, so it stays at its reset value.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else if (write_hit) begin
      regs[bus.i_addr_wr] <= bus.i_data_wr;
    end
  end

  // Stored-content lookups; address 0 is forced to zero independently of
  // the array so the zero register cannot be corrupted by any path.
  assign stored_a    = (bus.i_addr_a == ZERO_ADDR) ? '0 : regs[bus.i_addr_a];
  assign stored_b    = (bus.i_addr_b == ZERO_ADDR) ? '0 : regs[bus.i_addr_b];
  assign stored_dump = (dump_index == ZERO_ADDR) ? '0 : regs[dump_index];

`ifdef REGISTER_BANK_BYPASS_EN
  // Forward the in-flight write-back value to any read of the same address.
  assign bus.o_data_a    = (write_hit && bus.i_addr_a == bus.i_addr_wr) ? bus.i_data_wr : stored_a;
  assign bus.o_data_b    = (write_hit && bus.i_addr_b == bus.i_addr_wr) ? bus.i_data_wr : stored_b;
  assign bus.o_dump_data = (write_hit && dump_index == bus.i_addr_wr) ? bus.i_data_wr : stored_dump;
`else
  assign bus.o_data_a    = stored_a;
  assign bus.o_data_b    = stored_b;
  assign bus.o_dump_data = stored_dump;
`endif

  assign bus.o_dump_addr = dump_index;

  register_bank_dump_ctrl #(
    .REG_COUNT  (REG_COUNT),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_dump_ctrl (
    .clk   (i_clk),
    .rst   (i_reset),
    .start (bus.i_dump_start),
    .ready (bus.i_dump_ready),
    .valid (bus.o_dump_valid),
    .busy  (bus.o_dump_busy),
    .done  (bus.o_dump_done),
    .index (dump_index)
  );

endmodule

// File: tb/tb_register_bank.sv
// Directed testbench for register_bank: write/read, zero register,
// same-cycle write visibility, full dump streams with and without
// back-pressure, a write during a stalled beat, and reset mid-dump.
module tb_register_bank;
  import register_bank_pkg::*;

  localparam int BW = 32;
  localparam int RC = 32;
  localparam int AW = 5;

`ifdef REGISTER_BANK_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic i_clk = 1'b0;
  logic i_reset;

  register_bank_if #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW)) bus ();

  register_bank #(
    .BUS_WIDTH  (BW),
    .REG_COUNT  (RC),
    .ADDR_WIDTH (AW)
  ) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  int totalChecks = 0;
  int badChecks   = 0;
  logic [BW-1:0] model [RC];

  task automatic checkOutput(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [AW-1:0] waddr, input logic [BW-1:0] wdata,
                               input logic [AW-1:0] addrA, input logic [AW-1:0] addrB);
    bus.i_write_enable = we;
    bus.i_addr_wr      = waddr;
    bus.i_data_wr      = wdata;
    bus.i_addr_a       = addrA;
    bus.i_addr_b       = addrB;
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // mode 0: ready held high; mode 1: ready pattern 1-0-1 with a stray start.
  task automatic runDump(input int mode);
    int k;
    int cycles;
    int busyCycles;
    logic readyVal;
    k = 0;
    cycles = 0;
    busyCycles = 0;
    bus.i_dump_start = 1'b1;
    bus.i_dump_ready = 1'b1;
    step();
    bus.i_dump_start = 1'b0;
    while (k < RC && cycles < 200) begin
      readyVal = (mode == 0) ? 1'b1 : ((cycles % 3) != 1);
      bus.i_dump_ready = readyVal;
      bus.i_dump_start = (mode == 1 && cycles == 10);
      settle();
      checkOutput("dump_valid", BW'(bus.o_dump_valid), 1);
      checkOutput("dump_addr", BW'(bus.o_dump_addr), BW'(k));
      checkOutput("dump_data", bus.o_dump_data, model[k]);
      checkOutput("dump_done_early", BW'(bus.o_dump_done), 0);
      if (bus.o_dump_busy) busyCycles++;
      if (readyVal) k++;
      step();
      cycles++;
    end
    bus.i_dump_start = 1'b0;
    checkOutput("dump_drained", BW'(k), BW'(RC));
    checkOutput("dump_cycles", BW'(cycles), (mode == 0) ? 32 : 48);
    settle();
    checkOutput("done_pulse", BW'(bus.o_dump_done), 1);
    checkOutput("done_valid", BW'(bus.o_dump_valid), 0);
    if (bus.o_dump_busy) busyCycles++;
    step();
    settle();
    checkOutput("done_cleared", BW'(bus.o_dump_done), 0);
    checkOutput("busy_cleared", BW'(bus.o_dump_busy), 0);
    checkOutput("busy_cycles", BW'(busyCycles), BW'(cycles + 1));
  endtask

  initial begin
    bit sawDone;
    for (int i = 0; i < RC; i++) model[i] = '0;
    i_reset = 1'b0;
    applyStimulus(1'b0, '0, '0, '0, '0);
    bus.i_dump_start = 1'b0;
    bus.i_dump_ready = 1'b0;
    #1;
    i_reset = 1'b1;
    #1;
    $display("[TB] reset state");
    applyStimulus(1'b0, '0, '0, 5'd5, 5'd31);
    settle();
    checkOutput("rst_valid", BW'(bus.o_dump_valid), 0);
    checkOutput("rst_busy", BW'(bus.o_dump_busy), 0);
    checkOutput("rst_done", BW'(bus.o_dump_done), 0);
    checkOutput("rst_data_a", bus.o_data_a, 0);
    checkOutput("rst_data_b", bus.o_data_b, 0);
    step();
    step();
    i_reset = 1'b0;

    $display("[TB] write and read back");
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
    step();
    applyStimulus(1'b0, 5'd0, '0, 5'd5, 5'd0);
    settle();
    checkOutput("read_r5", bus.o_data_a, 32'hDEADBEEF);
    applyStimulus(1'b1, 5'd0, 32'h00001234, 5'd5, 5'd0);
    settle();
    checkOutput("r0_during_write", bus.o_data_b, 0);
    step();
    applyStimulus(1'b0, 5'd0, '0, 5'd5, 5'd0);
    settle();
    checkOutput("r0_after_write", bus.o_data_b, 0);
    checkOutput("r5_kept", bus.o_data_a, 32'hDEADBEEF);

    $display("[TB] same-cycle write visibility");
    applyStimulus(1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7);
    settle();
    checkOutput("same_cycle_a", bus.o_data_a, BYPASS ? 32'hA5A5A5A5 : 32'h0);
    checkOutput("same_cycle_b", bus.o_data_b, BYPASS ? 32'hA5A5A5A5 : 32'h0);
    step();
    applyStimulus(1'b0, 5'd0, '0, 5'd7, 5'd5);
    settle();
    checkOutput("next_cycle_a", bus.o_data_a, 32'hA5A5A5A5);

    $display("[TB] preload and full dump");
    for (int n = 1; n < RC; n++) begin
      applyStimulus(1'b1, AW'(n), BW'(n * 32'h11), 5'd0, 5'd0);
      model[n] = BW'(n * 32'h11);
      step();
    end
    applyStimulus(1'b0, 5'd0, '0, 5'd31, 5'd1);
    settle();
    checkOutput("preload_r31", bus.o_data_a, 32'h0000020F);
    checkOutput("preload_r1", bus.o_data_b, 32'h00000011);
    runDump(0);

    $display("[TB] dump with back-pressure");
    runDump(1);

    $display("[TB] write during stalled beat");
    bus.i_dump_start = 1'b1;
    bus.i_dump_ready = 1'b1;
    step();
    bus.i_dump_start = 1'b0;
    for (int j = 0; j < 3; j++) begin
      settle();
      checkOutput("stall_pre_addr", BW'(bus.o_dump_addr), BW'(j));
      step();
    end
    bus.i_dump_ready = 1'b0;
    settle();
    checkOutput("stall_addr", BW'(bus.o_dump_addr), 3);
    checkOutput("stall_data_old", bus.o_dump_data, 32'h33);
    applyStimulus(1'b1, 5'd3, 32'h55, 5'd0, 5'd0);
    settle();
    checkOutput("stall_same_cycle", bus.o_dump_data, BYPASS ? 32'h55 : 32'h33);
    step();
    applyStimulus(1'b0, 5'd0, '0, 5'd0, 5'd0);
    model[3] = 32'h55;
    settle();
    checkOutput("stall_new_data", bus.o_dump_data, 32'h55);
    checkOutput("stall_addr_held", BW'(bus.o_dump_addr), 3);
    checkOutput("stall_valid_held", BW'(bus.o_dump_valid), 1);
    bus.i_dump_ready = 1'b1;
    sawDone = 1'b0;
    for (int c = 0; c < 100 && !sawDone; c++) begin
      step();
      settle();
      if (bus.o_dump_done) sawDone = 1'b1;
    end
    checkOutput("stall_dump_done", BW'(sawDone), 1);
    step();

    $display("[TB] reset mid-dump");
    runDumpPrefix();
    i_reset = 1'b1;
    #1;
    checkOutput("abort_valid", BW'(bus.o_dump_valid), 0);
    checkOutput("abort_busy", BW'(bus.o_dump_busy), 0);
    checkOutput("abort_done", BW'(bus.o_dump_done), 0);
    checkOutput("abort_addr", BW'(bus.o_dump_addr), 0);
    applyStimulus(1'b0, 5'd0, '0, 5'd5, 5'd3);
    settle();
    checkOutput("abort_r5", bus.o_data_a, 0);
    checkOutput("abort_r3", bus.o_data_b, 0);
    for (int i = 0; i < RC; i++) model[i] = '0;
    step();
    i_reset = 1'b0;
    settle();
    checkOutput("post_reset_idle", BW'(bus.o_dump_busy), 0);
    step();
    checkOutput("post_reset_no_done", BW'(bus.o_dump_done), 0);
    runDump(0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

  // Starts a dump and advances it to beat 10 with ready held high.
  task automatic runDumpPrefix();
    bus.i_dump_start = 1'b1;
    bus.i_dump_ready = 1'b1;
    step();
    bus.i_dump_start = 1'b0;
    for (int j = 0; j < 10; j++) step();
    settle();
    checkOutput("beat10_addr", BW'(bus.o_dump_addr), 10);
    checkOutput("beat10_data", bus.o_dump_data, 32'hAA);
    checkOutput("beat10_busy", BW'(bus.o_dump_busy), 1);
  endtask

endmodule
